// File: rtl/csam_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : csam_round_norm
// Purpose  : Back end of the CSAM array multiplier. Takes the unsigned 2N-bit
//            product of two 1.(N-1) significands (format 2.(2N-2)), normalizes
//            it to 1.(N-1), rounds it in the selected mode and reports the
//            exponent adjustment plus inexact / zero flags.
//            Two-stage valid/ready pipeline:
//              stage 1 : normalize, extract guard / sticky
//              stage 2 : round, renormalize on carry-out
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   prod_i / rm_i valid this cycle
//            in_ready   stage 1 can accept (transfer on in_valid & in_ready)
//            prod_i     [2N-1:0] product, value in [0,4)
//            rm_i       [1:0] round mode: 00 RNE, 01 RZ, 10 RU, 11 RNA
//            out_valid  result valid
//            out_ready  consumer accepts (transfer on out_valid & out_ready)
//            res_o      [N-1:0] rounded significand 1.(N-1)
//            exp_adj_o  [1:0] exponent increment 0..2
//            inexact_o  guard | sticky nonzero
//            zero_o     product was zero
// Revision : 1.0 - initial release
// ============================================================================
module csam_round_norm #(
  parameter int N = 19          // significand width, must be >= 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   prod_i,
  input  logic [1:0]       rm_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     res_o,
  output logic [1:0]       exp_adj_o,
  output logic             inexact_o,
  output logic             zero_o
);

  localparam int PW = 2 * N;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RU  = 2'b10;
  localparam logic [1:0] RM_RNA = 2'b11;

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic             v1_q,   v1_d;
  logic [N-1:0]     m1_q,   m1_d;
  logic             g1_q,   g1_d;
  logic             s1_q,   s1_d;
  logic             sh1_q,  sh1_d;
  logic             z1_q,   z1_d;
  logic [1:0]       rm1_q,  rm1_d;

  logic             v2_q,   v2_d;
  logic [N-1:0]     res_q,  res_d;
  logic [1:0]       adj_q,  adj_d;
  logic             inx_q,  inx_d;
  logic             zero_q, zero_d;

  // --------------------------------------------------------------------------
  // Handshake: a stage is ready when empty or when it drains this cycle.
  // Purely combinational so a full pipeline still streams at 1/cycle.
  // --------------------------------------------------------------------------
  logic ready_s2;
  logic s1_load;
  logic s2_load;

  always_comb begin
    ready_s2 = !v2_q || out_ready;
    in_ready = !v1_q || ready_s2;
    s1_load  = in_valid && in_ready;
    s2_load  = v1_q && ready_s2;
  end

  // --------------------------------------------------------------------------
  // Stage 1 normalize. The product lies in [1,4) for normalized operands, so
  // only the top bit decides between a 1-bit right shift and none.
  // Products in (0,1) fall through the no-shift path unchanged.
  // --------------------------------------------------------------------------
  logic [N-1:0] norm_m;
  logic         norm_g;
  logic         norm_s;
  logic         norm_sh;
  logic         norm_zero;

  always_comb begin
    norm_sh   = prod_i[PW-1];
    norm_zero = ~|prod_i;
    if (norm_sh) begin
      norm_m = prod_i[PW-1:N];
      norm_g = prod_i[N-1];
      norm_s = |prod_i[N-2:0];
    end else begin
      norm_m = prod_i[PW-2:N-1];
      norm_g = prod_i[N-2];
      norm_s = |prod_i[N-3:0];
    end
  end

  always_comb begin
    v1_d  = v1_q;
    m1_d  = m1_q;
    g1_d  = g1_q;
    s1_d  = s1_q;
    sh1_d = sh1_q;
    z1_d  = z1_q;
    rm1_d = rm1_q;
    if (in_ready) begin
      // Either empty or handing its content to stage 2 this cycle.
      v1_d = in_valid;
    end
    if (s1_load) begin
      m1_d  = norm_m;
      g1_d  = norm_g;
      s1_d  = norm_s;
      sh1_d = norm_sh;
      z1_d  = norm_zero;
      rm1_d = rm_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 round. The increment decision uses only guard, sticky and the
  // LSB of the kept significand.
  // --------------------------------------------------------------------------
  logic         rnd_inc;
  logic [N:0]   rnd_sum;
  logic [N-1:0] rnd_res;
  logic [1:0]   rnd_adj;
  logic         rnd_inx;

  always_comb begin
    rnd_inc = 1'b0;
    case (rm1_q)
      RM_RNE:  rnd_inc = g1_q & (s1_q | m1_q[0]);
      RM_RZ:   rnd_inc = 1'b0;
      RM_RU:   rnd_inc = g1_q | s1_q;
      RM_RNA:  rnd_inc = g1_q;
      default: rnd_inc = 1'b0;
    endcase

    rnd_sum = {1'b0, m1_q} + {{N{1'b0}}, rnd_inc};
    rnd_inx = g1_q | s1_q;

    if (z1_q) begin
      rnd_res = '0;
      rnd_adj = 2'd0;
      rnd_inx = 1'b0;
    end else if (rnd_sum[N]) begin
      // Carry out of 1.11..1 + ulp: result is exactly 2.0, renormalize to 1.0.
      rnd_res = {1'b1, {(N-1){1'b0}}};
      rnd_adj = {1'b0, sh1_q} + 2'd1;
    end else begin
      rnd_res = rnd_sum[N-1:0];
      rnd_adj = {1'b0, sh1_q};
    end
  end

  always_comb begin
    v2_d   = v2_q;
    res_d  = res_q;
    adj_d  = adj_q;
    inx_d  = inx_q;
    zero_d = zero_q;
    if (ready_s2) begin
      v2_d = v1_q;
    end
    if (s2_load) begin
      res_d  = rnd_res;
      adj_d  = rnd_adj;
      inx_d  = rnd_inx;
      zero_d = z1_q;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      m1_q   <= '0;
      g1_q   <= 1'b0;
      s1_q   <= 1'b0;
      sh1_q  <= 1'b0;
      z1_q   <= 1'b0;
      rm1_q  <= 2'b00;
      v2_q   <= 1'b0;
      res_q  <= '0;
      adj_q  <= 2'd0;
      inx_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      m1_q   <= m1_d;
      g1_q   <= g1_d;
      s1_q   <= s1_d;
      sh1_q  <= sh1_d;
      z1_q   <= z1_d;
      rm1_q  <= rm1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
      adj_q  <= adj_d;
      inx_q  <= inx_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v2_q;
  assign res_o     = res_q;
  assign exp_adj_o = adj_q;
  assign inexact_o = inx_q;
  assign zero_o    = zero_q;

endmodule
`default_nettype wire
